resize_capture_buf: RTL and testbench

RESIZE_CAPTURE_BUF -- requirements
Module: resize_capture_buf

---
 rtl/resize_capture_buf.sv | 119 +++++++++++
 tb/tb_resize_capture_buf.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/resize_capture_buf.sv
// Double-buffered 32x32 grayscale capture buffer between a resizer and a pixel consumer.
// Optional frame-mean statistics are built when RESIZE_BUF_STATS_EN is defined.
module resize_capture_buf (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       iWr,
  input  logic [7:0] iPix,
  input  logic       iFrameDone,
  input  logic       iRdEn,
  input  logic [9:0] iRdAddr,
  input  logic       iClrErr,
  output logic [7:0] oRdData,
  output logic       oRdValid,
  output logic       oNewFrame,
  output logic       oFrameReady,
  output logic [7:0] oFrameCnt,
  output logic       oFrameErr,
  output logic [7:0] oFrameMean
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]  state, stateNxt;
  logic [10:0] wcnt, wcntNxt;
  logic        bad, badNxt;
  logic        bankSel;
  logic        accept;
  logic        frameGood, frameBad;

  // Both banks live in one array; the MSB of the index selects the bank.
  logic [7:0] mem [0:2047];

  // A pixel arriving with iFrameDone is counted before the frame is judged.
  always_comb begin
    accept    = iWr && (state != FULL);
    wcntNxt   = wcnt + {10'd0, accept};
    badNxt    = bad | (iWr && (state == FULL));
    frameGood = iFrameDone && (wcntNxt == 11'd1024) && !badNxt;
    frameBad  = iFrameDone && !frameGood && ((wcntNxt != 11'd0) || badNxt);
    if (frameGood || frameBad)
      stateNxt = EMPTY;
    else if (wcntNxt == 11'd0)
      stateNxt = EMPTY;
    else if (wcntNxt == 11'd1024)
      stateNxt = FULL;
    else
      stateNxt = FILL;
  end

  always_ff @(posedge clk) begin
    if (accept)
      mem[{bankSel, wcnt[9:0]}] <= iPix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      wcnt        <= 11'd0;
      bad         <= 1'b0;
      bankSel     <= 1'b0;
      oRdValid    <= 1'b0;
      oRdData     <= 8'h00;
      oNewFrame   <= 1'b0;
      oFrameReady <= 1'b0;
      oFrameCnt   <= 8'd0;
      oFrameErr   <= 1'b0;
    end else begin
      state     <= stateNxt;
      oNewFrame <= frameGood;
      if (frameGood || frameBad) begin
        wcnt <= 11'd0;
        bad  <= 1'b0;
      end else begin
        wcnt <= wcntNxt;
        bad  <= badNxt;
      end
      if (frameGood) begin
        bankSel     <= ~bankSel;
        oFrameReady <= 1'b1;
        oFrameCnt   <= oFrameCnt + 8'd1;
      end
      if (frameBad)
        oFrameErr <= 1'b1;
      else if (iClrErr)
        oFrameErr <= 1'b0;
      // Reads use the bank select before any swap in this cycle takes effect.
      oRdValid <= iRdEn;
      if (iRdEn)
        oRdData <= oFrameReady ? mem[{~bankSel, iRdAddr}] : 8'h00;
    end
  end

`ifdef RESIZE_BUF_STATS_EN
  logic [17:0] sum, sumNxt;

  always_comb begin
    sumNxt = sum + (accept ? {10'd0, iPix} : 18'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum        <= 18'd0;
      oFrameMean <= 8'h00;
    end else begin
      if (frameGood || frameBad)
        sum <= 18'd0;
      else
        sum <= sumNxt;
      if (frameGood)
        oFrameMean <= sumNxt[17:10];
    end
  end
`else
  assign oFrameMean = 8'h00;
`endif

endmodule

// File: tb/tb_resize_capture_buf.sv
// Directed bench for resize_capture_buf: queue-based frame model checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_resize_capture_buf;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       iWr = 1'b0;
  logic [7:0] iPix = 8'h00;
  logic       iFrameDone = 1'b0;
  logic       iRdEn = 1'b0;
  logic [9:0] iRdAddr = 10'd0;
  logic       iClrErr = 1'b0;
  logic [7:0] oRdData;
  logic       oRdValid;
  logic       oNewFrame;
  logic       oFrameReady;
  logic [7:0] oFrameCnt;
  logic       oFrameErr;
  logic [7:0] oFrameMean;

`ifdef RESIZE_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  resize_capture_buf dut (
    .clk(clk), .rst_n(rst_n), .iWr(iWr), .iPix(iPix), .iFrameDone(iFrameDone),
    .iRdEn(iRdEn), .iRdAddr(iRdAddr), .iClrErr(iClrErr), .oRdData(oRdData),
    .oRdValid(oRdValid), .oNewFrame(oNewFrame), .oFrameReady(oFrameReady),
    .oFrameCnt(oFrameCnt), .oFrameErr(oFrameErr), .oFrameMean(oFrameMean)
  );

  always #5 clk = ~clk;

  // Model state: frame being captured, last published frame, expected outputs.
  logic [7:0] cur[$];
  logic [7:0] pub [0:1023];
  bit         ovf = 0;
  bit         mValid = 0, mNew = 0, mReady = 0, mErr = 0;
  logic [7:0] mData = 0, mCnt = 0, mMean = 0;

  initial begin
    for (int i = 0; i < 1024; i++) pub[i] = 8'h00;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cur.delete();
        ovf = 0; mValid = 0; mNew = 0; mReady = 0; mErr = 0;
        mData = 0; mCnt = 0; mMean = 0;
      end else begin
        bit errNow;
        errNow = 0;
        mValid = iRdEn;
        if (iRdEn) mData = mReady ? pub[iRdAddr] : 8'h00;
        mNew = 0;
        if (iWr) begin
          if (cur.size() < 1024) cur.push_back(iPix);
          else ovf = 1;
        end
        if (iFrameDone && (cur.size() > 0 || ovf)) begin
          if (cur.size() == 1024 && !ovf) begin
            int s;
            s = 0;
            for (int i = 0; i < 1024; i++) begin
              pub[i] = cur[i];
              s += cur[i];
            end
            mNew = 1;
            mReady = 1;
            mCnt = mCnt + 8'd1;
            mMean = STATS ? 8'(s / 1024) : 8'h00;
          end else begin
            mErr = 1;
            errNow = 1;
          end
          cur.delete();
          ovf = 0;
        end
        if (!errNow && iClrErr) mErr = 0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("rdValid", oRdValid, mValid);
      if (mValid) chk("rdData", oRdData, mData);
      chk("newFrame", oNewFrame, mNew);
      chk("frameReady", oFrameReady, mReady);
      chk("frameCnt", oFrameCnt, mCnt);
      chk("frameErr", oFrameErr, mErr);
      chk("frameMean", oFrameMean, mMean);
    end
  end

  task automatic step(input logic wr, input logic [7:0] pix, input logic done,
                      input logic rd, input logic [9:0] addr, input logic clr);
    @(posedge clk);
    #1;
    iWr = wr; iPix = pix; iFrameDone = done;
    iRdEn = rd; iRdAddr = addr; iClrErr = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 8'h00, 0, 0, 10'd0, 0);
  endtask

  task automatic frame(input int n, input logic [7:0] val, input bit useIdx);
    for (int i = 0; i < n; i++) step(1, useIdx ? i[7:0] : val, 0, 0, 10'd0, 0);
  endtask

  // Issue a single read, then look at the result one cycle later.
  task automatic readLit(input string name, input logic [9:0] addr, input logic [7:0] exp);
    step(0, 8'h00, 0, 1, addr, 0);
    idle(1);
    @(negedge clk);
    chk({name, "_valid"}, oRdValid, 1);
    chk(name, oRdData, exp);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdValid", oRdValid, 0);
    chk("rst_rdData", oRdData, 8'h00);
    chk("rst_newFrame", oNewFrame, 0);
    chk("rst_ready", oFrameReady, 0);
    chk("rst_cnt", oFrameCnt, 0);
    chk("rst_err", oFrameErr, 0);
    chk("rst_mean", oFrameMean, 0);
    rst_n = 1'b1;
    idle(2);

    readLit("rd_notReady", 10'd5, 8'h00);

    // Full frame of i mod 256, then a separate end-of-frame pulse.
    frame(1024, 8'h00, 1);
    step(0, 8'h00, 1, 0, 10'd0, 0);
    idle(1);
    @(negedge clk);
    chk("f1_newFrame", oNewFrame, 1);
    chk("f1_cnt", oFrameCnt, 1);
    chk("f1_ready", oFrameReady, 1);
    chk("f1_mean", oFrameMean, STATS ? 8'h7F : 8'h00);
    readLit("f1_rd3FF", 10'h3FF, 8'hFF);
    readLit("f1_rd001", 10'h001, 8'h01);

    // Short frame: error, no swap.
    frame(1000, 8'h11, 0);
    step(0, 8'h00, 1, 0, 10'd0, 0);
    idle(1);
    @(negedge clk);
    chk("short_err", oFrameErr, 1);
    chk("short_newFrame", oNewFrame, 0);
    chk("short_cnt", oFrameCnt, 1);
    readLit("short_rd3FF", 10'h3FF, 8'hFF);
    step(0, 8'h00, 0, 0, 10'd0, 1);
    idle(1);
    @(negedge clk);
    chk("clr_err", oFrameErr, 0);

    // End-of-frame with nothing captured is ignored.
    step(0, 8'h00, 1, 0, 10'd0, 0);
    idle(1);
    @(negedge clk);
    chk("emptyDone_err", oFrameErr, 0);
    chk("emptyDone_cnt", oFrameCnt, 1);

    // Overflow frame.
    frame(1030, 8'h22, 0);
    step(0, 8'h00, 1, 0, 10'd0, 0);
    idle(1);
    @(negedge clk);
    chk("ovf_err", oFrameErr, 1);
    chk("ovf_cnt", oFrameCnt, 1);
    readLit("ovf_rd010", 10'h010, 8'h10);
    step(0, 8'h00, 0, 0, 10'd0, 1);
    idle(1);
    @(negedge clk);
    chk("ovf_clr", oFrameErr, 0);

    // Clear and a new error in the same cycle: error wins.
    frame(5, 8'h33, 0);
    step(0, 8'h00, 1, 0, 10'd0, 1);
    idle(1);
    @(negedge clk);
    chk("clrVsErr", oFrameErr, 1);
    step(0, 8'h00, 0, 0, 10'd0, 1);
    idle(1);

    // 1024th pixel coincides with end-of-frame; read in the swap cycle sees the old bank.
    frame(1023, 8'h80, 0);
    step(1, 8'h80, 1, 1, 10'h3FF, 0);
    idle(1);
    @(negedge clk);
    chk("coin_newFrame", oNewFrame, 1);
    chk("coin_cnt", oFrameCnt, 2);
    chk("coin_swapRd", oRdData, 8'hFF);
    chk("coin_mean", oFrameMean, STATS ? 8'h80 : 8'h00);
    readLit("coin_rd3FF", 10'h3FF, 8'h80);

    // Reset mid-fill, then a good frame.
    frame(500, 8'h44, 0);
    idle(1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midRst_cnt", oFrameCnt, 0);
    chk("midRst_ready", oFrameReady, 0);
    rst_n = 1'b1;
    idle(1);
    frame(1024, 8'h00, 1);
    step(0, 8'h00, 1, 0, 10'd0, 0);
    idle(1);
    @(negedge clk);
    chk("postRst_cnt", oFrameCnt, 1);
    chk("postRst_err", oFrameErr, 0);
    chk("postRst_newFrame", oNewFrame, 1);
    readLit("postRst_rd2AB", 10'h2AB, 8'hAB);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
